// File: rtl/mdu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_pkg                                                                  |
// | Shared definitions for the EX-stage multiply/divide unit: default        |
// | operand width, MDU opcode values and the sequencer state encoding.       |
// | Revision: 1.0  - initial release                                         |
// +--------------------------------------------------------------------------+
package mdu_pkg;

  // Default operand / HI / LO width. The iteration count equals this width.
  localparam int MDU_W = 32;

  // MDU opcodes as presented by EX. Opcodes 0-3 need the iterative datapath.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_iter_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_iter_core                                                            |
// | Shared one-bit-per-cycle datapath with a 2W-bit accumulator:             |
// |   multiply - shift-add, multiplier in acc low half, product grows from   |
// |              the top while the multiplier shifts out of the bottom.      |
// |   divide   - restoring, dividend in acc low half, remainder builds in    |
// |              the high half, quotient bits shift into the low half.       |
// | Operates on unsigned magnitudes only; sign handling is done by the       |
// | caller.                                                                  |
// | Ports:                                                                   |
// |   clk, rst    clock, synchronous active-high reset                       |
// |   load_i      capture operands and mode, clear accumulator high half     |
// |   step_i      perform one iteration                                      |
// |   div_i       mode captured on load: 1 divide, 0 multiply                |
// |   acc_lo_i    multiplier (mul) / dividend (div) magnitude                |
// |   oper_i      multiplicand (mul) / divisor (div) magnitude               |
// |   acc_nxt_o   accumulator value after the current iteration             |
// | Revision: 1.0  - initial release                                         |
// +--------------------------------------------------------------------------+
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int W = MDU_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [W-1:0]   acc_lo_i,
  input  logic [W-1:0]   oper_i,
  output logic [2*W-1:0] acc_nxt_o
);

  logic [2*W-1:0] acc_q;
  logic [W-1:0]   oper_q;
  logic           div_q;

  logic [W:0]     sum;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;

  always_comb begin
    // Multiply: add multiplicand into the high half, keep the carry.
    sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, oper_q};
    // Divide: partial remainder shifted left with the next dividend bit.
    rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    // Bit W set means the trial subtraction borrowed (remainder < divisor).
    diff   = rem_sh - {1'b0, oper_q};
    acc_nxt_o = acc_q;
    if (div_q) begin
      if (!diff[W]) acc_nxt_o = {diff[W-1:0],   acc_q[W-2:0], 1'b1};
      else          acc_nxt_o = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_nxt_o = {sum, acc_q[W-1:1]};
      else          acc_nxt_o = {1'b0, acc_q[2*W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      oper_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      acc_q  <= {{W{1'b0}}, acc_lo_i};
      oper_q <= oper_i;
      div_q  <= div_i;
    end else if (step_i) begin
      acc_q  <= acc_nxt_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mdu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mdu                                                                   |
// | EX-stage multiply/divide unit. Owns the architectural HI/LO registers,   |
// | runs MULT/MULTU/DIV/DIVU over W cycles while requesting a pipeline       |
// | stall, commits MTHI/MTLO immediately and supplies MFHI/MFLO data.        |
// | Ports:                                                                   |
// |   clk, rst    clock, synchronous active-high reset                       |
// |   op_valid    EX holds a valid MDU instruction                           |
// |   op          MDU opcode (see mdu_pkg)                                   |
// |   src_a       rs value: multiplicand / dividend / MT source              |
// |   src_b       rt value: multiplier / divisor                             |
// |   stallreq    hold IF..EX                                                |
// |   rdata       HI (MFHI) or LO (MFLO), else 0                             |
// |   hi, lo      current HI / LO contents                                   |
// |   done        one-cycle pulse when a mul/div result commits              |
// | Revision: 1.0  - initial release                                         |
// +--------------------------------------------------------------------------+
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int W = MDU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  output logic         stallreq,
  output logic [W-1:0] rdata,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         done
);

  localparam int CW = $clog2(W);

  mdu_state_e     state_q;
  logic [CW-1:0]  count_q;
  logic [W-1:0]   hi_q, lo_q, a_raw_q;
  logic           div_q, dz_q, neg_q, rneg_q, done_q;

  logic           accept, is_signed, is_div, a_neg, b_neg, last_iter;
  logic [W-1:0]   a_mag, b_mag, hi_d, lo_d, quo, rem;
  logic [2*W-1:0] acc_nxt, prod;

  // op[2]==0 selects the iterative ops; op[0]==0 selects the signed flavour.
  assign accept    = (state_q == S_IDLE) && op_valid && !op[2];
  assign is_signed = !op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed && src_a[W-1];
  assign b_neg     = is_signed && src_b[W-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign last_iter = (state_q == S_BUSY) && (count_q == CW'(W-1));

  mdu_iter_core #(.W(W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    ((state_q == S_BUSY) && !dz_q),
    .div_i     (is_div),
    .acc_lo_i  (is_div ? a_mag : b_mag),
    .oper_i    (is_div ? b_mag : a_mag),
    .acc_nxt_o (acc_nxt)
  );

  // Sign fix-up on the final iteration's result, committed at the same edge.
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[W-1:0];
    rem  = acc_nxt[2*W-1:W];
    hi_d = prod[2*W-1:W];
    lo_d = prod[W-1:0];
    if (div_q) begin
      if (dz_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else begin
        hi_d = rneg_q ? -rem : rem;
        lo_d = neg_q  ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_raw_q <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_BUSY;
            // Divide by zero skips straight to the final BUSY cycle.
            count_q <= (is_div && (src_b == '0)) ? CW'(W-1) : '0;
            div_q   <= is_div;
            dz_q    <= is_div && (src_b == '0);
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            a_raw_q <= src_a;
          end else if (op_valid && (op == OP_MTHI)) begin
            hi_q <= src_a;
          end else if (op_valid && (op == OP_MTLO)) begin
            lo_q <= src_a;
          end
        end
        S_BUSY: begin
          count_q <= count_q + CW'(1);
          if (last_iter) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallreq = accept || (state_q == S_BUSY);
  assign rdata    = (op_valid && (op == OP_MFHI)) ? hi_q :
                    (op_valid && (op == OP_MFLO)) ? lo_q : '0;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: doc/ex_mdu.md
# ex_mdu

Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Holds the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU iteratively, raising a stall request so IF–EX hold while MEM/WB drain. Also executes MTHI/MTLO and supplies MFHI/MFLO read data, which EX places on `ex_result` toward MEM.

## Interface
Parameters:
- `W`, 32, operand/HI/LO width; iteration count equals `W`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `op_valid`  in  1  EX holds a valid MDU instruction this cycle.
- `op`  in  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `src_a`  in  W  rs value (multiplicand/dividend; MTHI/MTLO source).
- `src_b`  in  W  rt value (multiplier/divisor).
- `stallreq`  out  1  request to the stall controller to hold IF–EX.
- `rdata`  out  W  HI for MFHI, LO for MFLO, else 0.
- `hi`, `lo`  out  W  current HI/LO register contents.
- `done`  out  1  one-cycle pulse: mul/div result just committed.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `op_valid` and op 0–3: latch operand magnitudes, signs and op; count←0; go BUSY.
- BUSY: one iteration per cycle; count increments; after iteration W−1: write HI/LO, go DONE.
- DONE: `done`=1, `stallreq`=0; EX still presents the same instruction; `op_valid` ignored; next cycle → IDLE.
- Multiply: 2W-bit shift-add on magnitudes (unsigned for MULTU); signed result negated if signs differ; HI←[2W−1:W], LO←[W−1:0].
- Divide: restoring, one quotient bit per cycle, on magnitudes. LO←quotient, negated if signs differ (DIV). HI←remainder, sign of dividend (DIV).
- Divide by zero: skips iterations; HI←src_a, LO←all ones; path still goes BUSY→DONE with count forced to W−1 (2 stall cycles).
- MTHI/MTLO in IDLE: write HI/LO at that edge, no stall.
- MFHI/MFLO: `rdata` combinational from HI/LO registers. A MF following an MT uses the post-write value because MT commits at its own EX edge.
- `stallreq` = (IDLE & `op_valid` & op≤3) | BUSY.
- `rst` at any time, including mid-BUSY: state IDLE, count 0, HI=LO=0, partial result discarded.

## Timing
- Reset values: `stallreq`=0, `rdata`=0, `hi`=`lo`=0, `done`=0.
- Mul/div accepted at edge E0. BUSY occupies cycles 1..W. HI/LO visible from cycle W+1 (DONE). Stall cycles: W+1 including the accept cycle (33 at W=32).
- Back-to-back MDU ops: second op seen no earlier than cycle after DONE; accepted normally.
- `stallreq` in the accept cycle is combinational from `op_valid`/`op` (no registered delay), so EX does not advance the instruction.
- No simultaneous MT and mul/div: single-issue guarantees one op per cycle.

## Structure
- `mdu_pkg`: opcode localparams (OP_MULT … OP_MFLO), state encoding, `W` default.
- One sub-module `mdu_iter_core`: shared W-iteration datapath (shift-add / restoring-subtract, 2W-bit accumulator); FSM, sign fix-up and HI/LO stay in `ex_mdu`.

## Test plan
- MULT −3 × 7 → after 33 stall cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulse once.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 → LO=14, HI=2.
- DIV 5 / 0 → 2 stall cycles, HI=5, LO=0xFFFFFFFF.
- MTHI 0x1234 then MFHI next cycle → `rdata`=0x1234, `stallreq` never asserted.
- `rst` at BUSY cycle 10 of a DIV → next cycle IDLE, `stallreq`=0, HI=LO=0, no `done`.
